// File: rtl/microc_stack.sv
`default_nettype none
// ============================================================================
//  Module   : microc_stack
//  Purpose  : Single-cycle 16-bit-instruction microcontroller datapath with
//             program counter, 16-entry register file, ALU, zero flag and a
//             hardware return-address stack for subroutine call/return.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   single clock, rising edge
//    reset      in   synchronous active-high reset
//    pc         out  [PCW-1:0] instruction address to program memory
//    instr      in   [15:0] instruction word at pc (combinational read)
//    s_inc      in   1: next pc = pc+1, 0: next pc = jump address
//    s_inm      in   1: operand B = zero-extended instr[11:4], RA1 = instr[3:0]
//    we         in   register-file write enable (address instr[3:0])
//    wez        in   zero-flag write enable
//    ALUOp      in   [2:0] ALU function
//    s_call     in   push pc+1, jump to instr[PCW-1:0]
//    s_ret      in   pop top of stack into pc
//    opcode     out  [5:0] instr[15:10]
//    zero       out  registered zero flag
//    sp_level   out  number of valid return-stack entries
//    stack_err  out  sticky overflow/underflow flag
// ============================================================================
module microc_stack #(
  parameter int DW    = 8,
  parameter int PCW   = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [PCW-1:0]               pc,
  input  logic [15:0]                  instr,
  input  logic                         s_inc,
  input  logic                         s_inm,
  input  logic                         we,
  input  logic                         wez,
  input  logic [2:0]                   ALUOp,
  input  logic                         s_call,
  input  logic                         s_ret,
  output logic [5:0]                   opcode,
  output logic                         zero,
  output logic [$clog2(DEPTH+1)-1:0]   sp_level,
  output logic                         stack_err
);

  localparam int SPW = $clog2(DEPTH+1);

  // --------------------------------------------------------------------------
  // Decode and register file
  // --------------------------------------------------------------------------
  logic [DW-1:0]  rf [16];
  logic [3:0]     ra1;
  logic [3:0]     ra2;
  logic [3:0]     wa3;
  logic [DW-1:0]  rd1;
  logic [DW-1:0]  rd2;
  logic [DW-1:0]  imm;
  logic [DW-1:0]  op_b;
  logic [DW-1:0]  alu_y;
  logic           alu_z;

  assign opcode = instr[15:10];
  // In immediate mode instr[11:4] holds the constant, so port 1 is steered
  // to the destination field and the ALU works accumulator-style.
  assign ra1    = s_inm ? instr[3:0] : instr[11:8];
  assign ra2    = instr[7:4];
  assign wa3    = instr[3:0];
  assign imm    = DW'(instr[11:4]);

  // R0 is hard-wired to zero on read; its storage is never written.
  assign rd1  = (ra1 == 4'd0) ? '0 : rf[ra1];
  assign rd2  = (ra2 == 4'd0) ? '0 : rf[ra2];
  assign op_b = s_inm ? imm : rd2;

  always_ff @(posedge clk) begin
    if (we && (wa3 != 4'd0)) begin
      rf[wa3] <= alu_y;
    end
  end

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  always_comb begin
    alu_y = '0;
    case (ALUOp)
      3'b000:  alu_y = rd1;
      3'b001:  alu_y = ~rd1;
      3'b010:  alu_y = rd1 + op_b;
      3'b011:  alu_y = rd1 - op_b;
      3'b100:  alu_y = rd1 & op_b;
      3'b101:  alu_y = rd1 | op_b;
      3'b110:  alu_y = '0 - rd1;
      default: alu_y = '0 - op_b;
    endcase
  end

  assign alu_z = (alu_y == '0);

  // --------------------------------------------------------------------------
  // Return-address stack
  // --------------------------------------------------------------------------
  logic [PCW-1:0] stack_mem [DEPTH];
  logic [PCW-1:0] stack_top;
  logic [PCW-1:0] pc_inc;
  logic [PCW-1:0] jump_addr;
  logic           stack_empty;
  logic           stack_full;
  logic           do_push;

  assign pc_inc      = pc + PCW'(1);
  assign jump_addr   = instr[PCW-1:0];
  assign stack_empty = (sp_level == '0);
  assign stack_full  = (sp_level == SPW'(DEPTH));
  // s_ret has priority, so a simultaneous call never pushes.
  assign do_push     = s_call && !s_ret && !stack_full && !reset;

  always_comb begin
    stack_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_level == SPW'(i + 1)) begin
        stack_top = stack_mem[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sp_level == SPW'(i)) begin
          stack_mem[i] <= pc_inc;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // PC, stack pointer and flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      zero      <= 1'b0;
      sp_level  <= '0;
      stack_err <= 1'b0;
    end else begin
      if (wez) begin
        zero <= alu_z;
      end

      if (s_ret) begin
        if (!stack_empty) begin
          pc       <= stack_top;
          sp_level <= sp_level - SPW'(1);
        end else begin
          pc        <= pc_inc;
          stack_err <= 1'b1;
        end
      end else if (s_call) begin
        pc <= jump_addr;
        if (!stack_full) begin
          sp_level <= sp_level + SPW'(1);
        end else begin
          stack_err <= 1'b1;
        end
      end else begin
        pc <= s_inc ? pc_inc : jump_addr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_microc_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_microc_stack
//  Purpose  : Directed self-checking bench for microc_stack. A default
//             instance (DW=8, PCW=10, DEPTH=4) and a wide/short instance
//             (DW=16, PCW=4, DEPTH=2) share the control inputs; the second
//             one is held in reset until its own steps.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_microc_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset2;
  logic [15:0] instr;
  logic        s_inc, s_inm, we, wez, s_call, s_ret;
  logic [2:0]  ALUOp;

  logic [9:0]  pc;
  logic [5:0]  opcode;
  logic        zero;
  logic [2:0]  sp_level;
  logic        stack_err;

  logic [3:0]  pc2;
  logic [5:0]  opcode2;
  logic        zero2;
  logic [1:0]  sp_level2;
  logic        stack_err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  microc_stack #(.DW(8), .PCW(10), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr), .s_inc(s_inc),
    .s_inm(s_inm), .we(we), .wez(wez), .ALUOp(ALUOp), .s_call(s_call),
    .s_ret(s_ret), .opcode(opcode), .zero(zero), .sp_level(sp_level),
    .stack_err(stack_err)
  );

  microc_stack #(.DW(16), .PCW(4), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset2), .pc(pc2), .instr(instr), .s_inc(s_inc),
    .s_inm(s_inm), .we(we), .wez(wez), .ALUOp(ALUOp), .s_call(s_call),
    .s_ret(s_ret), .opcode(opcode2), .zero(zero2), .sp_level(sp_level2),
    .stack_err(stack_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of control, then sample 1 time unit after the edge.
  task automatic cyc(input logic inc, input logic inm, input logic w, input logic wz,
                     input logic [2:0] op, input logic call, input logic ret,
                     input logic [15:0] ins);
    s_inc = inc; s_inm = inm; we = w; wez = wz; ALUOp = op;
    s_call = call; s_ret = ret; instr = ins;
    @(posedge clk);
    #1;
  endtask

  // Shorthands for control-flow-only cycles.
  task automatic jmp(input logic [15:0] a);  cyc(0, 0, 0, 0, 3'b000, 0, 0, a); endtask
  task automatic call(input logic [15:0] a); cyc(0, 0, 0, 0, 3'b000, 1, 0, a); endtask
  task automatic ret();                      cyc(0, 0, 0, 0, 3'b000, 0, 1, 16'h0000); endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    cyc(0, 0, 0, 0, 3'b000, 0, 0, 16'h0000);
    cyc(0, 0, 0, 0, 3'b000, 0, 0, 16'h0000);
    chk("rst_pc", pc, 0);
    chk("rst_zero", zero, 0);
    chk("rst_sp", sp_level, 0);
    chk("rst_err", stack_err, 0);
    chk("opcode", opcode, 6'h00);
    reset = 1'b0;

    // Sequential fetch
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 0, 0, 3'b000, 0, 0, 16'h0000);
      chk("inc_pc", pc, i);
    end
    chk("inc_zero", zero, 0);
    chk("inc_sp", sp_level, 0);

    // Immediates go in accumulator-style: R = R & 0, then R = R | imm.
    cyc(1, 1, 1, 0, 3'b100, 0, 0, 16'h0001);
    cyc(1, 1, 1, 0, 3'b101, 0, 0, 16'h0051);   // R1 = 5
    cyc(1, 1, 1, 0, 3'b100, 0, 0, 16'h0002);
    cyc(1, 1, 1, 0, 3'b101, 0, 0, 16'h0052);   // R2 = 5
    cyc(1, 0, 1, 1, 3'b011, 0, 0, 16'h0123);   // R3 = R1 - R2 = 0
    chk("sub_zero", zero, 1);
    cyc(1, 0, 1, 1, 3'b010, 0, 0, 16'h0124);   // R4 = R1 + R2 = 0x0A
    chk("add_zero", zero, 0);
    cyc(1, 1, 0, 1, 3'b011, 0, 0, 16'h00A4);   // R4 - 0x0A
    chk("r4_is_0a", zero, 1);
    cyc(1, 0, 0, 1, 3'b000, 0, 0, 16'h0300);   // A = R3
    chk("r3_is_0", zero, 1);
    cyc(1, 0, 1, 1, 3'b001, 0, 0, 16'h2000);   // ~R0 = 0xFF, opcode 0x08
    chk("opcode_08", opcode, 6'h08);
    chk("not_zero", zero, 0);

    // R0 protection: R0 | 0xFF written to R0, then R0 read back
    cyc(1, 1, 1, 1, 3'b101, 0, 0, 16'h0FF0);
    chk("r0w_zero", zero, 0);
    cyc(1, 0, 0, 1, 3'b000, 0, 0, 16'h0000);
    chk("r0_reads_0", zero, 1);

    // Call / return with nesting
    jmp(16'h0003);
    chk("jmp_pc", pc, 10'h003);
    call(16'h0020);
    chk("call1_pc", pc, 10'h020);
    chk("call1_sp", sp_level, 1);
    cyc(1, 0, 0, 0, 3'b000, 0, 0, 16'h0000);
    chk("sub_inc", pc, 10'h021);
    call(16'h0040);
    chk("call2_pc", pc, 10'h040);
    chk("call2_sp", sp_level, 2);
    ret();
    chk("ret1_pc", pc, 10'h022);
    chk("ret1_sp", sp_level, 1);
    ret();
    chk("ret2_pc", pc, 10'h004);
    chk("ret2_sp", sp_level, 0);
    chk("ret2_err", stack_err, 0);

    // Overflow: DEPTH+1 calls; return addresses 5, 0x101, 0x111, 0x121
    call(16'h0100);
    call(16'h0110);
    call(16'h0120);
    call(16'h0130);
    chk("full_sp", sp_level, 4);
    chk("full_err", stack_err, 0);
    call(16'h0140);
    chk("ovf_pc", pc, 10'h140);
    chk("ovf_sp", sp_level, 4);
    chk("ovf_err", stack_err, 1);
    ret(); chk("lifo1", pc, 10'h121);
    ret(); chk("lifo2", pc, 10'h111);
    ret(); chk("lifo3", pc, 10'h101);
    ret(); chk("lifo4", pc, 10'h005);
    chk("lifo_sp", sp_level, 0);

    // Reset clears the sticky error
    reset = 1'b1;
    ret();
    reset = 1'b0;
    chk("rst2_err", stack_err, 0);
    chk("rst2_pc", pc, 0);

    // Underflow
    jmp(16'h0007);
    ret();
    chk("unf_pc", pc, 10'h008);
    chk("unf_err", stack_err, 1);
    chk("unf_sp", sp_level, 0);

    // Simultaneous call+return with one entry: pop wins, nothing pushed
    call(16'h0050);                              // pushes 9
    chk("one_sp", sp_level, 1);
    cyc(0, 0, 0, 0, 3'b000, 1, 1, 16'h0060);
    chk("both_pc", pc, 10'h009);
    chk("both_sp", sp_level, 0);

    // PC wrap for increment and pushed return address
    jmp(16'h03FF);
    cyc(1, 0, 0, 0, 3'b000, 0, 0, 16'h0000);
    chk("wrap_inc", pc, 10'h000);
    jmp(16'h03FF);
    call(16'h0010);
    ret();
    chk("wrap_ret", pc, 10'h000);

    // Reset during an active call
    call(16'h0030);
    call(16'h0060);
    chk("deep_sp", sp_level, 2);
    reset = 1'b1;
    call(16'h0070);
    reset = 1'b0;
    chk("rstc_pc", pc, 0);
    chk("rstc_sp", sp_level, 0);

    // Wide instance: 0xFF zero-extends, so 0x00FF + 1 = 0x0100 is nonzero;
    // in the 8-bit instance the same sequence wraps to 0.
    reset2 = 1'b0;
    chk("w_rst_pc", pc2, 0);
    chk("w_rst_sp", sp_level2, 0);
    cyc(1, 1, 1, 0, 3'b100, 0, 0, 16'h0001);
    cyc(1, 1, 1, 0, 3'b101, 0, 0, 16'h0FF1);
    cyc(1, 1, 1, 1, 3'b010, 0, 0, 16'h0011);
    chk("w_zext", zero2, 0);
    chk("n_wrap8", zero, 1);
    cyc(1, 1, 0, 1, 3'b011, 0, 0, 16'h0011);   // R1 - 1 = 0x00FF
    chk("w_sub", zero2, 0);
    cyc(1, 1, 0, 1, 3'b011, 0, 0, 16'h0FF1);   // 0x0100 - 0x00FF = 1
    chk("w_nonzero", zero2, 0);
    jmp(16'h000F);
    chk("w_pc_f", pc2, 4'hF);
    cyc(1, 0, 0, 0, 3'b000, 0, 0, 16'h0000);
    chk("w_wrap", pc2, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
